// File: rtl/sample_ctrl_pkg.sv
// sample_ctrl_pkg: shared state/cause encodings and SRAM map defaults for the capture sequencer
package sample_ctrl_pkg;
  localparam int HDR_BYTES_DEF = 128;
  localparam int REV_BYTES_DEF = 16384;
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ARM   = 5'b00010,
    S_RUN   = 5'b00100,
    S_DRAIN = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;
  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_TARGET  = 2'b01,
    CAUSE_TIMEOUT = 2'b10,
    CAUSE_ABORT   = 2'b11
  } cause_t;
  function automatic logic [7:0] clamp_tgt(input logic [7:0] rt, input int max_rev);
    return rt == 8'd0 ? 8'd1 : (int'(rt) > max_rev ? 8'(max_rev) : rt);
  endfunction
endpackage

// File: rtl/sample_ctrl_if.sv
// sample_ctrl_if: MCU command and sample-stage control bundle of the capture sequencer
interface sample_ctrl_if;
  import sample_ctrl_pkg::*;
  logic start;
  logic abort;
  logic [7:0] rev_target;
  logic sample_en;
  logic sample_end;
  logic [7:0] sync_cnt;
  logic [19:0] addr_base;
  logic busy;
  cause_t done_cause;
  modport master (output start, abort, rev_target,
                  input sample_en, sample_end, sync_cnt, addr_base, busy, done_cause);
  modport slave (input start, abort, rev_target,
                 output sample_en, sample_end, sync_cnt, addr_base, busy, done_cause);
endinterface

// File: rtl/sample_ctrl_sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer with rising-edge pulse taken against a third flop
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);
  logic [2:0] sr;
  always_ff @(posedge clk)
    sr <= rst ? 3'b000 : {sr[1:0], din};
  assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/sample_ctrl.sv
// sample_ctrl: arms an encoder capture, steps SRAM regions per sync edge and ends on target/timeout/abort
module sample_ctrl
  import sample_ctrl_pkg::*;
#(
  parameter int          HDR_BYTES = HDR_BYTES_DEF,
  parameter int          REV_BYTES = REV_BYTES_DEF,
  parameter int          MAX_REV   = 63,
  parameter logic [23:0] TIMEOUT   = 24'hFFFFFF,
  parameter int          DRAIN     = 8
) (
  input logic         clk,
  input logic         rst,
  input logic         ch_sync_in,
  sample_ctrl_if.slave bus
);
  localparam logic [19:0] HDR     = 20'(HDR_BYTES);
  localparam logic [23:0] DRAIN_C = 24'(DRAIN);
  state_t state, state_nx;
  cause_t cause, cause_nx;
  logic [7:0] cnt, cnt_nx, cnt_inc, tgt;
  logic [19:0] addr, addr_nx;
  logic [23:0] tmr, tmr_nx;
  logic sync_ev, busy;
  sync_edge_det u_sync (.clk(clk), .rst(rst), .din(ch_sync_in), .pulse(sync_ev));
  assign tgt     = clamp_tgt(bus.rev_target, MAX_REV);
  assign cnt_inc = cnt == 8'hFF ? cnt : cnt + 8'd1;
  assign busy    = state == S_ARM || state == S_RUN || state == S_DRAIN;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cause <= CAUSE_NONE;
      cnt   <= 8'd0;
      addr  <= HDR;
      tmr   <= 24'd0;
    end else begin
      state <= state_nx;
      cause <= cause_nx;
      cnt   <= cnt_nx;
      addr  <= addr_nx;
      tmr   <= tmr_nx;
    end
  end
  // tmr doubles as the sync timeout counter in ARM/RUN and the drain counter in DRAIN
  always_comb begin
    state_nx = state;
    cause_nx = cause;
    cnt_nx   = cnt;
    addr_nx  = addr;
    tmr_nx   = tmr;
    if (bus.abort && (busy || bus.start)) begin
      state_nx = S_DONE;
      cause_nx = CAUSE_ABORT;
    end else if (!busy) begin
      if (bus.start) begin
        state_nx = S_ARM;
        cause_nx = CAUSE_NONE;
        cnt_nx   = 8'd0;
        addr_nx  = HDR;
        tmr_nx   = 24'd0;
      end
    end else if (state == S_DRAIN) begin
      if (tmr == DRAIN_C) state_nx = S_DONE;
      else tmr_nx = tmr + 24'd1;
    end else if (sync_ev) begin
      cnt_nx  = cnt_inc;
      addr_nx = 20'(HDR_BYTES + (int'(cnt_inc) - 1) * REV_BYTES);
      tmr_nx  = 24'd0;
      if (state == S_ARM) state_nx = S_RUN;
      else if (cnt_inc == tgt + 8'd1) begin
        state_nx = S_DRAIN;
        cause_nx = CAUSE_TARGET;
      end
    end else if (tmr == TIMEOUT) begin
      state_nx = S_DONE;
      cause_nx = CAUSE_TIMEOUT;
    end else tmr_nx = tmr + 24'd1;
  end
  assign bus.sample_en  = busy;
  assign bus.sample_end = ~busy;
  assign bus.busy       = busy;
  assign bus.sync_cnt   = cnt;
  assign bus.addr_base  = addr;
  assign bus.done_cause = cause;
endmodule

// File: doc/sample_ctrl.md
# sample_ctrl

Capture sequencer that sits directly upstream of the encoder sample/write stage. It arms a capture on an MCU command and detects encoder sync (index) edges. It drives the stage's `sample_en`, `sync_cnt`, `addr_base` and `sample_end` inputs so that each revolution's edge timestamps land in their own SRAM region. It ends the capture after a programmed number of revolutions, on a sync timeout, or on an MCU abort, and then hands the RAM bus to the MCU.

## Interface
Parameters:
- `HDR_BYTES`, 128 – byte size of the per-revolution header table at SRAM address 0.
- `REV_BYTES`, 16384 – byte size of one revolution region (4096 four-byte records).
- `MAX_REV`, 63 – upper clamp on the revolution target.
- `TIMEOUT`, 24'hFFFFFF – clock cycles without a sync edge before the capture ends.
- `DRAIN`, 8 – cycles `sample_en` is held after the final sync edge.

Ports:
- `clk` in 1 – single clock; all logic is on its rising edge.
- `rst` in 1 – reset, synchronous and active-high.
- `ch_sync_in` in 1 – raw encoder sync input, asynchronous.
- `start` in 1 – MCU arm command, one-cycle pulse.
- `abort` in 1 – MCU stop command, one-cycle pulse.
- `rev_target` in 8 – number of complete revolutions to capture.
- `sample_en` out 1 – capture enable to the sample stage.
- `sample_end` out 1 – capture finished; the MCU owns the RAM.
- `sync_cnt` out 8 – number of sync edges seen since arm.
- `addr_base` out 20 – base byte address of the current revolution region.
- `busy` out 1 – high in ARM, RUN and DRAIN.
- `done_cause` out 2 – reason the capture ended: 00 none, 01 target reached, 10 timeout, 11 abort.

## Operation
- States: IDLE, ARM, RUN, DRAIN, DONE (one-hot).
- Effective target: `tgt = clamp(rev_target, 1, MAX_REV)`.
- IDLE:
  - `start` → ARM.
  - On this transition: `sync_cnt` = 0, `addr_base` = HDR_BYTES, timeout counter cleared, `done_cause` = 00, `sample_end` = 0, `sample_en` = 1.
- ARM: the first sync edge → RUN.
- RUN: the sync edge that makes `sync_cnt` = tgt+1 → DRAIN, with `done_cause` = 01.
- Sync edge effect, in ARM or RUN: `sync_cnt` increments, saturating at 255. `addr_base` becomes `HDR_BYTES + (new sync_cnt − 1)·REV_BYTES`, truncated to 20 bits (wraps). The timeout counter clears.
- Timeout: counter reaches TIMEOUT in ARM or RUN → DONE directly, `done_cause` = 10.
- Abort: `abort` in ARM, RUN or DRAIN → DONE directly, `done_cause` = 11.
- DRAIN:
  - Counts DRAIN cycles with `sample_en` still 1, so the final header and record writes complete.
  - Then → DONE.
  - Further sync edges are ignored.
- DONE:
  - `sample_en` = 0, `sample_end` = 1.
  - `start` → ARM, re-arming as from IDLE.
- `start` is ignored in ARM, RUN and DRAIN.

## Timing
- Sync path:
  - 2-flop synchronizer, then a rising-edge detect registered on the 3rd flop.
  - `sync_cnt` and `addr_base` update 1 cycle after the edge-detect pulse.
  - The sample stage therefore sees the pre-increment `sync_cnt` at its own edge detect.
- `start` → `sample_en` = 1 on the next cycle; → `busy` = 1 on the next cycle.
- Target edge → `sample_end` = 1 exactly DRAIN+1 cycles after `sync_cnt` reaches tgt+1.
- Timeout and abort → `sample_end` = 1 on the next cycle.
- Simultaneous events, by priority:
  - `abort` beats everything.
  - A sync edge beats a timeout in the same cycle: the counter clears and there is no timeout.
  - `start` together with `abort` in IDLE or DONE: abort wins, and the block stays or enters DONE.
- Reset values:
  - State IDLE; `sample_en` 0, `sample_end` 1, `sync_cnt` 0, `addr_base` HDR_BYTES, `busy` 0, `done_cause` 00.
  - Synchronizer flops 0.
- `rst` mid-capture returns all of the above to reset values on the next edge; no drain occurs.

## Structure
- Shared package holds:
  - state encodings;
  - `done_cause` codes;
  - `HDR_BYTES` and `REV_BYTES` defaults, also used by the sample stage and the MCU address map.
- One sub-module, `sync_edge_det`: 2-flop synchronizer plus rising-edge pulse, synchronous active-high reset. It is reusable for `ch_sgn_in` conditioning.

## Test plan
- Target reached: reset, `rev_target` = 3, `start`, 5 sync pulses 1000 cycles apart.
  - `sync_cnt` goes 1,2,3,4; `addr_base` goes 0x80, 0x4080, 0x8080, 0xC080.
  - `sample_end` rises DRAIN+1 cycles after the 4th edge; `done_cause` = 01.
  - The 5th pulse is ignored.
- Timeout: `TIMEOUT` = 100, `start`, no sync.
  - `sample_end` = 1 and `done_cause` = 10 at 101 cycles after ARM entry.
- Timeout race: sync edge detected on the same cycle the counter hits TIMEOUT.
  - Count increments, no timeout, state stays RUN.
- Abort in DRAIN.
  - DONE on the next cycle; `done_cause` = 11; `sample_en` = 0 immediately.
- Clamp and wrap:
  - `rev_target` = 0 behaves as 1.
  - `rev_target` = 200 clamps to 63.
  - `REV_BYTES` = 0x40000 makes `addr_base` wrap modulo 2^20.
- Reset and re-arm:
  - `rst` mid-RUN gives all reset values.
  - `start` after DONE re-arms: `sync_cnt` = 0, `done_cause` = 00.
